// File: rtl/barvinn_csr_mvu_bridge.sv
// rtl/barvinn_csr_mvu_bridge.sv - pito CSR to MVU array bridge: banked job regs, launch, busy/err/irq tracking
module barvinn_csr_mvu_bridge #(
    parameter int NHART  = 8,
    parameter int NCFG   = 8,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      csr_we,
    input  logic                      csr_re,
    input  logic [2:0]                csr_hart,
    input  logic [11:0]               csr_addr,
    input  logic [DATA_W-1:0]         csr_wdata,
    output logic [DATA_W-1:0]         csr_rdata,
    output logic                      csr_hit,
    output logic [NHART*NCFG*32-1:0]  mvu_cfg,
    output logic [NHART-1:0]          mvu_start,
    input  logic [NHART-1:0]          mvu_done,
    output logic [NHART-1:0]          hart_irq,
    output logic [NHART-1:0]          mvu_busy
);

    localparam logic [11:0] A_CFG  = 12'hF20;
    localparam logic [11:0] A_CMD  = 12'hF28;
    localparam logic [11:0] A_STAT = 12'hF29;
    localparam int          CW     = (NCFG > 1) ? $clog2(NCFG) : 1;

    logic [DATA_W-1:0] cfg [NHART][NCFG];
    logic [NHART-1:0]  busy, err, irq;

    logic              hart_ok, cfg_hit, cmd_hit, stat_hit, hit;
    logic [11:0]       cfg_off;
    logic [DATA_W-1:0] rd_val;
    logic [NHART-1:0]  launch, stat_wr, done_v, busy_nd;

    always_comb begin
        hart_ok  = ({1'b0, csr_hart} < 4'(NHART));
        cfg_off  = csr_addr - A_CFG;
        cfg_hit  = (csr_addr >= A_CFG) && (cfg_off < 12'(NCFG));
        cmd_hit  = (csr_addr == A_CMD);
        stat_hit = (csr_addr == A_STAT);
        hit      = hart_ok && (cfg_hit || cmd_hit || stat_hit);

        // Registers are read before this cycle's write lands, so a combined
        // read+write returns the old value.
        rd_val = '0;
        if (hart_ok && cfg_hit)
            rd_val = cfg[csr_hart][cfg_off[CW-1:0]];
        else if (hart_ok && stat_hit)
            rd_val[2:0] = {irq[csr_hart], err[csr_hart], busy[csr_hart]};

        for (int i = 0; i < NHART; i++) begin
            launch[i]  = csr_we && hart_ok && (csr_hart == 3'(i)) && cmd_hit;
            stat_wr[i] = csr_we && hart_ok && (csr_hart == 3'(i)) && stat_hit;
        end
        // Done is applied before launch, so a same-cycle done frees the MVU.
        done_v  = mvu_done & busy;
        busy_nd = busy & ~done_v;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg       <= '{default: '0};
            busy      <= '0;
            err       <= '0;
            irq       <= '0;
            mvu_start <= '0;
            csr_rdata <= '0;
            csr_hit   <= 1'b0;
        end else begin
            if (csr_we || csr_re) begin
                csr_hit   <= hit;
                csr_rdata <= (csr_re && hit) ? rd_val : '0;
            end
            if (csr_we && hart_ok && cfg_hit)
                cfg[csr_hart][cfg_off[CW-1:0]] <= csr_wdata;

            mvu_start <= launch & ~busy_nd;
            busy      <= busy_nd | launch;
            // Sticky flags: a same-cycle set beats a software clear.
            err <= (launch & busy_nd) | (err & ~(stat_wr & {NHART{csr_wdata[1]}}));
            irq <= done_v | (irq & ~(stat_wr & {NHART{csr_wdata[2]}}));
        end
    end

    always_comb begin
        mvu_cfg = '0;
        for (int i = 0; i < NHART; i++)
            for (int k = 0; k < NCFG; k++)
                mvu_cfg[(i*NCFG+k)*32 +: 32] = cfg[i][k][31:0];
    end

    assign hart_irq = irq;
    assign mvu_busy = busy;

endmodule

// File: tb/tb_barvinn_csr_mvu_bridge.sv
// tb/tb_barvinn_csr_mvu_bridge.sv - directed self-checking bench for barvinn_csr_mvu_bridge
module tb_barvinn_csr_mvu_bridge;

    logic          clk = 1'b0;
    logic          rst;
    logic          csr_we, csr_re;
    logic [2:0]    csr_hart;
    logic [11:0]   csr_addr;
    logic [31:0]   csr_wdata;
    logic [31:0]   csr_rdata;
    logic          csr_hit;
    logic [2047:0] mvu_cfg;
    logic [7:0]    mvu_start, mvu_done, hart_irq, mvu_busy;

    int checks = 0;
    int errors = 0;

    barvinn_csr_mvu_bridge #(.NHART(8), .NCFG(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .csr_we(csr_we), .csr_re(csr_re), .csr_hart(csr_hart),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
        .mvu_cfg(mvu_cfg), .mvu_start(mvu_start), .mvu_done(mvu_done),
        .hart_irq(hart_irq), .mvu_busy(mvu_busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus on a falling edge, release on the next one.
    task automatic access(input logic we, input logic re, input logic [2:0] hart,
                          input logic [11:0] addr, input logic [31:0] wd, input logic [7:0] done);
        @(negedge clk);
        csr_we = we; csr_re = re; csr_hart = hart; csr_addr = addr; csr_wdata = wd; mvu_done = done;
        @(negedge clk);
        csr_we = 1'b0; csr_re = 1'b0; csr_wdata = '0; mvu_done = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if ({mvu_start, mvu_busy, hart_irq} !== 24'h0) begin errors++;
            $display("FAIL reset_flags got %h want 000000", {mvu_start, mvu_busy, hart_irq}); end
        checks++; if (mvu_cfg !== '0) begin errors++; $display("FAIL reset_cfg got nonzero want 0"); end
        checks++; if ({csr_hit, csr_rdata} !== 33'h0) begin errors++;
            $display("FAIL reset_csr got %h want 0", {csr_hit, csr_rdata}); end
        access(1'b0, 1'b1, 3'd3, 12'hF20, 32'h0, 8'h0);
        checks++; if (csr_rdata !== 32'h0 || csr_hit !== 1'b1) begin errors++;
            $display("FAIL reset_read got %h/%b want 0/1", csr_rdata, csr_hit); end
    endtask

    task automatic test_job_regs;
        access(1'b1, 1'b0, 3'd2, 12'hF23, 32'hDEADBEEF, 8'h0);
        access(1'b0, 1'b1, 3'd2, 12'hF23, 32'h0, 8'h0);
        checks++; if (csr_rdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL cfg_readback got %h want deadbeef", csr_rdata); end
        checks++; if (mvu_cfg[(2*8+3)*32 +: 32] !== 32'hDEADBEEF) begin errors++;
            $display("FAIL cfg_flat got %h want deadbeef", mvu_cfg[(2*8+3)*32 +: 32]); end
        access(1'b0, 1'b1, 3'd5, 12'hF23, 32'h0, 8'h0);
        checks++; if (csr_rdata !== 32'h0) begin errors++;
            $display("FAIL cfg_banked got %h want 0", csr_rdata); end
        access(1'b0, 1'b1, 3'd2, 12'h300, 32'h0, 8'h0);
        checks++; if (csr_rdata !== 32'h0 || csr_hit !== 1'b0) begin errors++;
            $display("FAIL unmapped got %h/%b want 0/0", csr_rdata, csr_hit); end
    endtask

    task automatic test_launch_done;
        access(1'b1, 1'b0, 3'd1, 12'hF28, 32'h0, 8'h0);
        checks++; if (mvu_start !== 8'h02 || mvu_busy !== 8'h02) begin errors++;
            $display("FAIL launch got start=%h busy=%h want 02/02", mvu_start, mvu_busy); end
        access(1'b0, 1'b1, 3'd1, 12'hF29, 32'h0, 8'h0);
        checks++; if (mvu_start !== 8'h00) begin errors++;
            $display("FAIL start_width got %h want 00", mvu_start); end
        checks++; if (csr_rdata !== 32'h1) begin errors++;
            $display("FAIL stat_busy got %h want 1", csr_rdata); end
        access(1'b0, 1'b1, 3'd1, 12'hF28, 32'h0, 8'h0);
        checks++; if (csr_rdata !== 32'h0 || csr_hit !== 1'b1) begin errors++;
            $display("FAIL cmd_read got %h/%b want 0/1", csr_rdata, csr_hit); end
        access(1'b0, 1'b0, 3'd1, 12'h0, 32'h0, 8'h02);
        checks++; if (mvu_busy !== 8'h00 || hart_irq !== 8'h02) begin errors++;
            $display("FAIL done got busy=%h irq=%h want 00/02", mvu_busy, hart_irq); end
        access(1'b0, 1'b1, 3'd1, 12'hF29, 32'h0, 8'h0);
        checks++; if (csr_rdata !== 32'h4) begin errors++;
            $display("FAIL stat_irq got %h want 4", csr_rdata); end
        access(1'b1, 1'b0, 3'd1, 12'hF29, 32'h4, 8'h0);
        checks++; if (hart_irq !== 8'h00) begin errors++;
            $display("FAIL irq_clear got %h want 00", hart_irq); end
    endtask

    task automatic test_launch_busy;
        access(1'b1, 1'b0, 3'd0, 12'hF28, 32'h0, 8'h0);
        access(1'b1, 1'b0, 3'd0, 12'hF28, 32'h0, 8'h0);
        checks++; if (mvu_start !== 8'h00) begin errors++;
            $display("FAIL relaunch_pulse got %h want 00", mvu_start); end
        access(1'b0, 1'b1, 3'd0, 12'hF29, 32'h0, 8'h0);
        checks++; if (csr_rdata !== 32'h3) begin errors++;
            $display("FAIL stat_err got %h want 3", csr_rdata); end
        access(1'b1, 1'b0, 3'd0, 12'hF29, 32'h2, 8'h0);
        access(1'b0, 1'b1, 3'd0, 12'hF29, 32'h0, 8'h0);
        checks++; if (csr_rdata !== 32'h1) begin errors++;
            $display("FAIL err_clear got %h want 1", csr_rdata); end
        access(1'b0, 1'b0, 3'd0, 12'h0, 32'h0, 8'h01);
        access(1'b1, 1'b0, 3'd0, 12'hF29, 32'h4, 8'h0);
    endtask

    task automatic test_done_and_launch;
        access(1'b1, 1'b0, 3'd4, 12'hF28, 32'h0, 8'h0);
        access(1'b1, 1'b0, 3'd4, 12'hF28, 32'h0, 8'h10);
        checks++; if (mvu_start !== 8'h10 || mvu_busy !== 8'h10 || hart_irq !== 8'h10) begin errors++;
            $display("FAIL done_launch got start=%h busy=%h irq=%h want 10/10/10", mvu_start, mvu_busy, hart_irq); end
        access(1'b0, 1'b1, 3'd4, 12'hF29, 32'h0, 8'h0);
        checks++; if (csr_rdata !== 32'h5) begin errors++;
            $display("FAIL done_launch_stat got %h want 5", csr_rdata); end
        access(1'b0, 1'b0, 3'd4, 12'h0, 32'h0, 8'h10);
        access(1'b1, 1'b0, 3'd4, 12'hF29, 32'h4, 8'h0);
    endtask

    task automatic test_irq_set_wins;
        access(1'b1, 1'b0, 3'd3, 12'hF28, 32'h0, 8'h0);
        access(1'b1, 1'b0, 3'd3, 12'hF29, 32'h4, 8'h08);
        checks++; if (hart_irq !== 8'h08 || mvu_busy !== 8'h00) begin errors++;
            $display("FAIL irq_set_wins got irq=%h busy=%h want 08/00", hart_irq, mvu_busy); end
        access(1'b1, 1'b0, 3'd3, 12'hF29, 32'h4, 8'h0);
    endtask

    task automatic test_rw_same_cycle;
        access(1'b1, 1'b0, 3'd6, 12'hF20, 32'h11, 8'h0);
        access(1'b1, 1'b1, 3'd6, 12'hF20, 32'h22, 8'h0);
        checks++; if (csr_rdata !== 32'h11) begin errors++;
            $display("FAIL rw_old_value got %h want 11", csr_rdata); end
        checks++; if (mvu_cfg[(6*8)*32 +: 32] !== 32'h22) begin errors++;
            $display("FAIL rw_stored got %h want 22", mvu_cfg[(6*8)*32 +: 32]); end
    endtask

    task automatic test_reset_mid_job;
        access(1'b1, 1'b0, 3'd7, 12'hF28, 32'h0, 8'h0);
        checks++; if (mvu_busy !== 8'h80) begin errors++;
            $display("FAIL job7_busy got %h want 80", mvu_busy); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (mvu_busy !== 8'h00 || hart_irq !== 8'h00) begin errors++;
            $display("FAIL mid_reset got busy=%h irq=%h want 00/00", mvu_busy, hart_irq); end
        access(1'b0, 1'b0, 3'd7, 12'h0, 32'h0, 8'h80);
        checks++; if ({mvu_busy, hart_irq, mvu_start} !== 24'h0) begin errors++;
            $display("FAIL stale_done got %h want 000000", {mvu_busy, hart_irq, mvu_start}); end
    endtask

    initial begin
        rst = 1'b1; csr_we = 1'b0; csr_re = 1'b0; csr_hart = '0; csr_addr = '0;
        csr_wdata = '0; mvu_done = '0;
        test_reset;
        test_job_regs;
        test_launch_done;
        test_launch_busy;
        test_done_and_launch;
        test_irq_set_wins;
        test_rw_same_cycle;
        test_reset_mid_job;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
